// File: rtl/branch_predictor.sv
// Gshare direction predictor: 2-bit saturating counters indexed by PC xor global history,
// swept to weak-not-taken after reset, with combinational multi-port lookup.
package sys;
    typedef logic [31:0] addr_t;
    typedef logic        bool_t;
endpackage

package core;
    localparam int peval_width = 2;

    typedef struct packed {
        sys::addr_t base_pc;
    } branch_pred_req_t;

    typedef struct packed {
        logic       valid;
        sys::addr_t base_pc;
        logic       branch_taken;
    } branch_pred_fb_t;

    typedef struct packed {
        logic branch_taken;
        logic eval_alt;
    } branch_pred_rsp_t;

    localparam branch_pred_rsp_t branch_pred_rsp_default = '{branch_taken: 1'b0, eval_alt: 1'b1};
endpackage

// state | meaning
// INIT  | sweeping every counter to 01, lookups report low confidence
// READY | predicting and training from resolved branches
module branch_predictor #(
    parameter int peval_width = core::peval_width,
    parameter int index_bits  = 8,
    parameter int ghr_bits    = 4
) (
    input  logic                   clk,
    input  sys::bool_t             rst,
    input  core::branch_pred_req_t branch_pred_req [peval_width],
    input  core::branch_pred_fb_t  branch_pred_fb,
    output core::branch_pred_rsp_t branch_pred_rsp [peval_width],
    output sys::bool_t             init_done
);
    localparam int entries = 2 ** index_bits;
    localparam int ghr_w   = (ghr_bits > 0) ? ghr_bits : 1;

    typedef enum logic {INIT, READY} state_t;

    state_t                state, state_next;
    logic [index_bits:0]   init_ctr, init_ctr_next;
    logic [ghr_w-1:0]      ghr, ghr_next, ghr_shift;
    logic [index_bits-1:0] ghr_idx;
    logic [1:0]            table_q [entries];

    logic                  tbl_we;
    logic [index_bits-1:0] tbl_waddr;
    logic [1:0]            tbl_wdata;
    logic [index_bits-1:0] fb_idx;
    logic [1:0]            fb_old, fb_ctr;

    // Bimodal configuration keeps a 1-bit history register pinned at zero.
    if (ghr_bits == 0) begin : g_bimodal
        assign ghr_idx   = '0;
        assign ghr_shift = '0;
        wire unused_ghr = ^ghr;
    end else if (ghr_bits == 1) begin : g_ghr1
        assign ghr_idx   = index_bits'(ghr);
        assign ghr_shift = branch_pred_fb.branch_taken;
    end else begin : g_ghrn
        assign ghr_idx   = index_bits'(ghr);
        assign ghr_shift = {ghr[ghr_w-2:0], branch_pred_fb.branch_taken};
    end

    assign fb_idx = branch_pred_fb.base_pc[index_bits+1:2] ^ ghr_idx;
    assign fb_old = table_q[fb_idx];
    wire unused_fb_pc = ^branch_pred_fb.base_pc;

    always_comb begin
        fb_ctr = fb_old;
        if (branch_pred_fb.branch_taken) begin
            if (fb_old != 2'b11) fb_ctr = fb_old + 2'b01;
        end else begin
            if (fb_old != 2'b00) fb_ctr = fb_old - 2'b01;
        end
    end

    always_comb begin
        state_next    = state;
        init_ctr_next = init_ctr;
        ghr_next      = ghr;
        tbl_we        = 1'b0;
        tbl_waddr     = fb_idx;
        tbl_wdata     = fb_ctr;
        case (state)
            INIT: begin
                tbl_we        = 1'b1;
                tbl_waddr     = init_ctr[index_bits-1:0];
                tbl_wdata     = 2'b01;
                init_ctr_next = init_ctr + 1'b1;
                if (init_ctr == (index_bits + 1)'(entries - 1)) state_next = READY;
            end
            READY: begin
                if (branch_pred_fb.valid) begin
                    tbl_we   = 1'b1;
                    ghr_next = ghr_shift;
                end
            end
            default: state_next = INIT;
        endcase
        if (rst) begin
            state_next    = INIT;
            init_ctr_next = '0;
            ghr_next      = '0;
            tbl_we        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state    <= state_next;
        init_ctr <= init_ctr_next;
        ghr      <= ghr_next;
    end

    // Single write port, no reset: maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (tbl_we) table_q[tbl_waddr] <= tbl_wdata;
    end

    assign init_done = (state == READY);

    for (genvar p = 0; p < peval_width; p++) begin : g_lookup
        logic [index_bits-1:0] idx;
        logic [1:0]            ctr;
        wire unused_req_pc = ^branch_pred_req[p].base_pc;

        assign idx = branch_pred_req[p].base_pc[index_bits+1:2] ^ ghr_idx;
        assign ctr = table_q[idx];

        always_comb begin
            branch_pred_rsp[p] = core::branch_pred_rsp_default;
            if (state == READY && !rst) begin
                branch_pred_rsp[p].branch_taken = ctr[1];
                branch_pred_rsp[p].eval_alt     = (ctr == 2'b01) || (ctr == 2'b10);
            end
        end
    end
endmodule
